pow_arbiter: RTL and testbench
==============================

POW_ARBITER -- requirements
Module: pow_arbiter

Interface
REQ-001 Parameter: TMO, 63, watchdog limit in cycles spent waiting for engine completion (range 1..255).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req  in  4  per-requester request; held high by requester until its gnt bit pulses.
REQ-005 req_x  in  64  four 16-bit bases; requester i on bits [16i+15:16i].
REQ-006 req_n  in  32  four 8-bit exponents; requester i on bits [8i+7:8i].
REQ-007 gnt  out  4  one-hot, one-cycle pulse: request i accepted, operands captured.
REQ-008 done  out  4  one-hot, one-cycle pulse: result for requester i valid on res/err this cycle.
REQ-009 res  out  16  result x^n mod 2^16; holds last value until next done.
REQ-010 err  out  1  qualifies done: 1 = watchdog expiry, res = 0.
REQ-011 busy  out  1  high from the grant cycle until the done cycle inclusive.
REQ-012 eng_start  out  1  start strobe to shared exponentiation engine.
REQ-013 eng_x  out  16, eng_n  out  8  engine operands, held stable from grant until done.
REQ-014 eng_ready  in  1  engine idle/complete flag; drops the cycle after start is sampled, rises with result.
REQ-015 eng_out  in  16  engine result, valid when eng_ready rises.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT; all outputs registered.
REQ-017 IDLE: on an edge with any req bit high and eng_ready=1, select winner w by round-robin, register gnt[w]=1, eng_start=1, eng_x=x_w, eng_n=n_w, busy=1, move to ISSUE.
REQ-018 IDLE with eng_ready=0: no grant, remain IDLE, requests stay pending.
REQ-019 Round-robin: search starts at pointer p, ascending mod 4; first set req bit wins; p resets to 0.
REQ-020 ISSUE: next edge unconditionally clears gnt and eng_start, clears watchdog counter, moves to WAIT.
REQ-021 WAIT: on an edge with eng_ready=1, register res=eng_out, err=0, done[w]=1, set p=(w+1) mod 4, move to IDLE.
REQ-022 WAIT: each edge with eng_ready=0 increments the 8-bit watchdog counter; at counter=TMO, register done[w]=1, err=1, res=0, p=(w+1) mod 4, move to IDLE.
REQ-023 done, err (as a done qualifier), gnt and eng_start are exactly one cycle wide; busy falls the cycle after done.
REQ-024 Latency: grant 1 cycle after a qualifying IDLE edge; done = engine busy time + 2 cycles after grant.
REQ-025 req bits seen in ISSUE or WAIT are ignored, not queued; the requester keeps req high.
REQ-026 A request withdrawn before its grant is dropped, with no gnt or done.
REQ-027 A requester may reassert in its own done cycle; it competes in the next IDLE cycle at the lowest priority (p advanced past it).
REQ-028 Arbiter performs no arithmetic; results are width-truncated by the engine only.

Reset
REQ-029 rst high asynchronously forces IDLE, p=0, gnt=0, done=0, eng_start=0, busy=0, err=0, res=0, eng_x=0, eng_n=0, watchdog=0.
REQ-030 Reset mid-operation aborts the transaction with no done; the first grant after rst falls requires eng_ready=1.

Verification
REQ-031 req[0], x=3, n=5 -> gnt[0] next cycle; done[0] with res=243, err=0; busy spans grant..done.
REQ-032 req[2], x=9, n=0 -> done[2] with res=1 two cycles after engine completes its 1-cycle busy.
REQ-033 req=4'b1111 held, each reasserted after done -> grant order 0,1,2,3,0; no grant while busy.
REQ-034 req[1], x=2, n=16 -> res=0 (wrap mod 2^16); x=7, n=3 -> res=343.
REQ-035 Engine model holds eng_ready=0 after start -> done[w] with err=1, res=0 exactly TMO cycles into WAIT; next grant goes to (w+1) mod 4.
REQ-036 rst pulsed during WAIT -> all outputs 0 immediately, no done; after release req[3] -> gnt[3] first.

Source files
------------

// File: rtl/pow_arbiter.sv
// Round-robin front end that shares one exponentiation engine among four requesters.
// Each request is granted, issued to the engine, and completed by a result or a watchdog expiry.
module pow_arbiter #(
    parameter int unsigned TMO = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [63:0] req_x,
    input  logic [31:0] req_n,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic [15:0] res,
    output logic        err,
    output logic        busy,
    output logic        eng_start,
    output logic [15:0] eng_x,
    output logic [7:0]  eng_n,
    input  logic        eng_ready,
    input  logic [15:0] eng_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] TMO_C = 8'(TMO);

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  win_q, win_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  done_q, done_d;
    logic [15:0] res_q, res_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        start_q, start_d;
    logic [15:0] x_q, x_d;
    logic [7:0]  n_q, n_d;
    logic [7:0]  wd_q, wd_d;
    logic [2:0]  pick_s;
    logic [7:0]  wd_inc_s;

    // Returns {found, index}: first set request at or after p, ascending mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + k[1:0];
            if (r[idx]) begin
                pick = {1'b1, idx};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        gnt_d    = 4'b0000;
        done_d   = 4'b0000;
        res_d    = res_q;
        err_d    = 1'b0;
        busy_d   = busy_q;
        start_d  = 1'b0;
        x_d      = x_q;
        n_d      = n_q;
        wd_d     = wd_q;
        pick_s   = rr_pick(req, ptr_q);
        wd_inc_s = wd_q + 8'd1;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (pick_s[2] && eng_ready) begin
                    win_d   = pick_s[1:0];
                    gnt_d   = 4'b0001 << pick_s[1:0];
                    start_d = 1'b1;
                    x_d     = req_x[{pick_s[1:0], 4'b0000} +: 16];
                    n_d     = req_n[{pick_s[1:0], 3'b000} +: 8];
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                wd_d    = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_ready) begin
                    res_d   = eng_out;
                    done_d  = 4'b0001 << win_q;
                    ptr_d   = win_q + 2'd1;
                    state_d = IDLE;
                end else if (wd_inc_s == TMO_C) begin
                    // Watchdog expiry completes the slot with an error and a zero result.
                    wd_d    = wd_inc_s;
                    res_d   = 16'd0;
                    err_d   = 1'b1;
                    done_d  = 4'b0001 << win_q;
                    ptr_d   = win_q + 2'd1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_inc_s;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            win_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            done_q  <= 4'b0000;
            res_q   <= 16'd0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            x_q     <= 16'd0;
            n_q     <= 8'd0;
            wd_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            x_q     <= x_d;
            n_q     <= n_d;
            wd_q    <= wd_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign res       = res_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign eng_start = start_q;
    assign eng_x     = x_q;
    assign eng_n     = n_q;

endmodule

// File: tb/tb_pow_arbiter.sv
// Bench for pow_arbiter: behavioural engine, done-event monitor and expected-result scoreboard.
module tb_pow_arbiter;

    localparam int TMO = 63;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_x;
    logic [31:0] req_n;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [15:0] res;
    logic        err;
    logic        busy;
    logic        eng_start;
    logic [15:0] eng_x;
    logic [7:0]  eng_n;
    logic        eng_ready;
    logic [15:0] eng_out;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {logic [3:0] done; logic [15:0] res; logic err; int cyc;} obs_t;
    typedef struct {logic [3:0] done; logic [15:0] res; logic err;} exp_t;
    typedef struct {int id; logic [15:0] x; logic [7:0] n; int lat; logic [15:0] exp;} vec_t;

    obs_t obs_q[$];
    exp_t exp_q[$];

    pow_arbiter #(.TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_n(req_n),
        .gnt(gnt), .done(done), .res(res), .err(err), .busy(busy),
        .eng_start(eng_start), .eng_x(eng_x), .eng_n(eng_n),
        .eng_ready(eng_ready), .eng_out(eng_out)
    );

    always #5 clk = ~clk;

    // Behavioural engine: busy for eng_lat cycles, or forever while eng_hang is set.
    int          eng_lat = 1;
    logic        eng_hang = 1'b0;
    logic        eng_block = 1'b0;
    logic        eng_rdy_r;
    logic [15:0] eng_res_r;
    int          eng_cnt;

    function automatic logic [15:0] pow16(input logic [15:0] x, input logic [7:0] n);
        logic [15:0] r;
        r = 16'd1;
        for (int i = 0; i < int'(n); i++) r = r * x;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_rdy_r <= 1'b1;
            eng_out   <= 16'd0;
            eng_res_r <= 16'd0;
            eng_cnt   <= 0;
        end else if (eng_rdy_r && eng_start) begin
            eng_rdy_r <= 1'b0;
            eng_cnt   <= eng_lat;
            eng_res_r <= pow16(eng_x, eng_n);
        end else if (!eng_rdy_r && !eng_hang) begin
            if (eng_cnt <= 1) begin
                eng_rdy_r <= 1'b1;
                eng_out   <= eng_res_r;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    assign eng_ready = eng_rdy_r & ~eng_block;

    function automatic int onehot_idx(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return k;
        return -1;
    endfunction

    // Advance to the next falling edge, log done events, drop requests that were granted.
    task automatic step();
        obs_t o;
        @(negedge clk);
        cyc++;
        if (done !== 4'b0000) begin
            o.done = done; o.res = res; o.err = err; o.cyc = cyc;
            obs_q.push_back(o);
        end
        for (int i = 0; i < 4; i++) if (gnt[i]) req[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [15:0] x, input logic [7:0] n);
        req_x[16*i +: 16] = x;
        req_n[8*i +: 8]   = n;
        req[i]            = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b0; req_x = 64'd0; req_n = 32'd0;
        step(); step();
        vectors++;
        if ({gnt, done, res, err, busy, eng_start, eng_x, eng_n} !== 51'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got gnt=%b done=%b res=%0d err=%b busy=%b start=%b x=%0d n=%0d, expected all zero",
                     gnt, done, res, err, busy, eng_start, eng_x, eng_n);
        end
        rst = 1'b0;
        step();
    endtask

    vec_t tbl[4] = '{
        '{0, 16'd3, 8'd5,  3, 16'd243},
        '{2, 16'd9, 8'd0,  1, 16'd1},
        '{1, 16'd2, 8'd16, 2, 16'd0},
        '{1, 16'd7, 8'd3,  4, 16'd343}
    };

    task automatic test_single();
        int t, g;
        logic busy_ok;
        obs_t o;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            eng_lat = tbl[k].lat;
            e.done = 4'b0001 << tbl[k].id; e.res = tbl[k].exp; e.err = 1'b0;
            exp_q.push_back(e);
            set_req(tbl[k].id, tbl[k].x, tbl[k].n);
            t = 0;
            do begin step(); t++; end while (gnt == 4'b0 && t < 20);
            vectors++;
            if (gnt !== (4'b0001 << tbl[k].id) || t != 1) begin
                miscompares++;
                $display("FAIL single_gnt[%0d]: got gnt=%b after %0d cycles, expected %b after 1", k, gnt, t, 4'b0001 << tbl[k].id);
            end
            g = cyc; busy_ok = 1'b1; t = 0;
            while (done == 4'b0 && t < 100) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                step(); t++;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL single_done[%0d]: got no done within budget, expected done=%b", k, e.done);
            end else begin
                o = obs_q.pop_front();
                if (o.done !== e.done || o.res !== e.res || o.err !== e.err) begin
                    miscompares++;
                    $display("FAIL single_result[%0d]: got done=%b res=%0d err=%b, expected done=%b res=%0d err=%b",
                             k, o.done, o.res, o.err, e.done, e.res, e.err);
                end
                vectors++;
                if (o.cyc - g != tbl[k].lat + 2) begin
                    miscompares++;
                    $display("FAIL single_latency[%0d]: got %0d cycles grant-to-done, expected %0d", k, o.cyc - g, tbl[k].lat + 2);
                end
            end
            vectors++;
            if (!busy_ok) begin
                miscompares++;
                $display("FAIL single_busy_span[%0d]: got busy low between grant and done, expected high", k);
            end
            step();
            vectors++;
            if (busy !== 1'b0 || done !== 4'b0 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL single_after_done[%0d]: got busy=%b done=%b err=%b, expected 0 0 0", k, busy, done, err);
            end
        end
    endtask

    task automatic test_not_ready();
        int t;
        logic quiet;
        obs_t o;
        exp_t e;
        eng_lat = 2; eng_block = 1'b1; quiet = 1'b1;
        e.done = 4'b1000; e.res = 16'd25; e.err = 1'b0;
        exp_q.push_back(e);
        set_req(3, 16'd5, 8'd2);
        for (int i = 0; i < 6; i++) begin
            step();
            if (gnt !== 4'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        vectors++;
        if (!quiet) begin
            miscompares++;
            $display("FAIL not_ready_hold: got a grant or busy while engine not ready, expected none");
        end
        eng_block = 1'b0;
        step();
        vectors++;
        if (gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL not_ready_release: got gnt=%b, expected 1000", gnt);
        end
        t = 0;
        while (done == 4'b0 && t < 100) begin step(); t++; end
        e = exp_q.pop_front();
        vectors++;
        if (obs_q.size() == 0) begin
            miscompares++;
            $display("FAIL not_ready_done: got no done, expected done=%b", e.done);
        end else begin
            o = obs_q.pop_front();
            if (o.done !== e.done || o.res !== e.res || o.err !== e.err) begin
                miscompares++;
                $display("FAIL not_ready_result: got done=%b res=%0d err=%b, expected done=%b res=%0d err=%b",
                         o.done, o.res, o.err, e.done, e.res, e.err);
            end
        end
        step();
    endtask

    task automatic test_round_robin();
        int t, ngr, id;
        int order[5];
        int want[5] = '{0, 1, 2, 3, 0};
        logic [15:0] rres[5] = '{16'd8, 16'd27, 16'd64, 16'd125, 16'd8};
        logic inflight, overlap;
        obs_t o;
        exp_t e;
        eng_lat = 1;
        for (int i = 0; i < 5; i++) begin
            e.done = 4'b0001 << want[i]; e.res = rres[i]; e.err = 1'b0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 4; i++) set_req(i, 16'(i + 2), 8'd3);
        ngr = 0; inflight = 1'b0; overlap = 1'b0; t = 0;
        while ((ngr < 5 || inflight) && t < 300) begin
            step(); t++;
            if (gnt !== 4'b0) begin
                if (inflight) overlap = 1'b1;
                inflight = 1'b1;
                if (ngr < 5) order[ngr] = onehot_idx(gnt);
                ngr++;
                if (ngr == 5) req = 4'b0;
            end
            if (done !== 4'b0) begin
                inflight = 1'b0;
                id = onehot_idx(done);
                if (ngr < 5 && id >= 0) req[id] = 1'b1;
            end
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (i >= ngr || order[i] != want[i]) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: got requester %0d (grants=%0d), expected %0d", i, (i < ngr) ? order[i] : -1, ngr, want[i]);
            end
        end
        vectors++;
        if (overlap) begin
            miscompares++;
            $display("FAIL rr_overlap: got a grant while a transaction was in flight, expected none");
        end
        for (int i = 0; i < 5; i++) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL rr_done[%0d]: got no done, expected done=%b res=%0d", i, e.done, e.res);
            end else begin
                o = obs_q.pop_front();
                if (o.done !== e.done || o.res !== e.res || o.err !== e.err) begin
                    miscompares++;
                    $display("FAIL rr_result[%0d]: got done=%b res=%0d err=%b, expected done=%b res=%0d err=%b",
                             i, o.done, o.res, o.err, e.done, e.res, e.err);
                end
            end
        end
        step();
    endtask

    task automatic test_watchdog();
        int t, g;
        logic quiet;
        obs_t o;
        exp_t e;
        eng_hang = 1'b1;
        e.done = 4'b0100; e.res = 16'd0; e.err = 1'b1;
        exp_q.push_back(e);
        set_req(2, 16'd4, 8'd4);
        t = 0;
        do begin step(); t++; end while (gnt == 4'b0 && t < 20);
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL wd_gnt: got gnt=%b, expected 0100", gnt);
        end
        g = cyc; t = 0;
        while (done == 4'b0 && t < TMO + 20) begin step(); t++; end
        e = exp_q.pop_front();
        vectors++;
        if (obs_q.size() == 0) begin
            miscompares++;
            $display("FAIL wd_done: got no done within budget, expected done=%b err=1", e.done);
        end else begin
            o = obs_q.pop_front();
            if (o.done !== e.done || o.res !== e.res || o.err !== e.err || o.cyc - g != TMO + 1) begin
                miscompares++;
                $display("FAIL wd_result: got done=%b res=%0d err=%b after %0d cycles, expected done=%b res=0 err=1 after %0d",
                         o.done, o.res, o.err, o.cyc - g, e.done, TMO + 1);
            end
        end
        step();
        vectors++;
        if (err !== 1'b0 || done !== 4'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_pulse: got err=%b done=%b busy=%b, expected 0 0000 0", err, done, busy);
        end
        eng_hang = 1'b0; t = 0;
        while (eng_ready !== 1'b1 && t < 20) begin step(); t++; end
        e.done = 4'b1000; e.res = 16'd100; e.err = 1'b0;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) set_req(i, 16'd10, 8'd2);
        t = 0;
        do begin step(); t++; end while (gnt == 4'b0 && t < 20);
        vectors++;
        if (gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL wd_next_gnt: got gnt=%b, expected 1000", gnt);
        end
        req = 4'b0;
        t = 0;
        while (done == 4'b0 && t < 100) begin step(); t++; end
        e = exp_q.pop_front();
        vectors++;
        if (obs_q.size() == 0) begin
            miscompares++;
            $display("FAIL wd_next_done: got no done, expected done=%b", e.done);
        end else begin
            o = obs_q.pop_front();
            if (o.done !== e.done || o.res !== e.res || o.err !== e.err) begin
                miscompares++;
                $display("FAIL wd_next_result: got done=%b res=%0d err=%b, expected done=%b res=%0d err=%b",
                         o.done, o.res, o.err, e.done, e.res, e.err);
            end
        end
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (gnt !== 4'b0 || done !== 4'b0) quiet = 1'b0;
        end
        vectors++;
        if (!quiet) begin
            miscompares++;
            $display("FAIL withdrawn_dropped: got gnt/done after requests withdrawn, expected none");
        end
    endtask

    task automatic test_reset_mid();
        int t;
        logic quiet;
        obs_t o;
        exp_t e;
        eng_hang = 1'b1;
        set_req(1, 16'd3, 8'd3);
        t = 0;
        do begin step(); t++; end while (gnt == 4'b0 && t < 20);
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL rmid_gnt: got gnt=%b, expected 0010", gnt);
        end
        for (int i = 0; i < 4; i++) step();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({gnt, done, res, err, busy, eng_start, eng_x, eng_n} !== 51'd0) begin
            miscompares++;
            $display("FAIL rmid_outputs: got gnt=%b done=%b res=%0d err=%b busy=%b start=%b x=%0d n=%0d, expected all zero",
                     gnt, done, res, err, busy, eng_start, eng_x, eng_n);
        end
        eng_hang = 1'b0;
        step(); step();
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (gnt !== 4'b0 || done !== 4'b0) quiet = 1'b0;
        end
        vectors++;
        if (!quiet || obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL rmid_no_done: got gnt/done after reset abort (queued=%0d), expected none", obs_q.size());
        end
        e.done = 4'b1000; e.res = 16'd36; e.err = 1'b0;
        exp_q.push_back(e);
        set_req(3, 16'd6, 8'd2);
        t = 0;
        do begin step(); t++; end while (gnt == 4'b0 && t < 20);
        vectors++;
        if (gnt !== 4'b1000 || t != 1) begin
            miscompares++;
            $display("FAIL rmid_first_gnt: got gnt=%b after %0d cycles, expected 1000 after 1", gnt, t);
        end
        t = 0;
        while (done == 4'b0 && t < 100) begin step(); t++; end
        e = exp_q.pop_front();
        vectors++;
        if (obs_q.size() == 0) begin
            miscompares++;
            $display("FAIL rmid_done: got no done, expected done=%b", e.done);
        end else begin
            o = obs_q.pop_front();
            if (o.done !== e.done || o.res !== e.res || o.err !== e.err) begin
                miscompares++;
                $display("FAIL rmid_result: got done=%b res=%0d err=%b, expected done=%b res=%0d err=%b",
                         o.done, o.res, o.err, e.done, e.res, e.err);
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_not_ready();
        test_round_robin();
        test_watchdog();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
